// File: rtl/fused_fetch_scheduler.sv
// fused_fetch_scheduler
//   Streams three BRAM regions (layer-1 weights, layer-2 weights, IFM) to a
//   consumer in fixed order, one read per consumer-ready cycle. Outside a
//   sequence the host may preload the BRAM through the write path.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   start                      one-cycle request to begin a fetch sequence
//   load_phase                 host owns the BRAM port (IDLE only)
//   we_global_initial          host write enable
//   wr_addr_global_initial     host write address
//   base_addr_*, size_*        region base word address / length in words
//   bram_addr, bram_we, bram_re  BRAM port
//   bram_rdata                 BRAM read data, one cycle after bram_re
//   out_ready                  consumer can take a word next cycle
//   out_valid, out_data, out_sel  fetched word and source tag (0 IFM, 1 W1, 2 W2)
//   busy, done                 sequence active / one-cycle completion pulse
//   load_conflict              sticky: host write attempted while busy
//   perf_stall_cnt             FETCH cycles with out_ready=0 (FETCH_PERF_CNT_EN only)
//
// Build option: define FETCH_PERF_CNT_EN to add the stall counter port.
module fused_fetch_scheduler #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              load_phase,
  input  logic              we_global_initial,
  input  logic [ADDR_W-1:0] wr_addr_global_initial,
  input  logic [ADDR_W-1:0] base_addr_IFM,
  input  logic [ADDR_W-1:0] size_IFM,
  input  logic [ADDR_W-1:0] base_addr_Weight_layer_1,
  input  logic [ADDR_W-1:0] size_Weight_layer_1,
  input  logic [ADDR_W-1:0] base_addr_Weight_layer_2,
  input  logic [ADDR_W-1:0] size_Weight_layer_2,
  output logic [ADDR_W-1:0] bram_addr,
  output logic              bram_we,
  output logic              bram_re,
  input  logic [DATA_W-1:0] bram_rdata,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_sel,
  output logic              busy,
  output logic              done,
  output logic              load_conflict
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_stall_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH_W1, S_FETCH_W2, S_FETCH_IFM, S_DRAIN, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] base_w1_q, size_w1_q, base_w2_q, size_w2_q, base_ifm_q, size_ifm_q;
  logic              out_valid_q;
  logic [1:0]        out_sel_q;
  logic              load_conflict_q;

  logic              accept_start;
  logic              in_fetch;
  logic              rd_last;
  logic [1:0]        rd_sel;
  logic [ADDR_W-1:0] cur_base, cur_size;

  assign accept_start = (state_q == S_IDLE) && start && !load_phase;

  // State register plus datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      base_w1_q       <= '0;
      size_w1_q       <= '0;
      base_w2_q       <= '0;
      size_w2_q       <= '0;
      base_ifm_q      <= '0;
      size_ifm_q      <= '0;
      out_valid_q     <= 1'b0;
      out_sel_q       <= '0;
      load_conflict_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= bram_re;
      out_sel_q   <= rd_sel;
      if (busy && we_global_initial) load_conflict_q <= 1'b1;
      if (accept_start) begin
        base_w1_q  <= base_addr_Weight_layer_1;
        size_w1_q  <= size_Weight_layer_1;
        base_w2_q  <= base_addr_Weight_layer_2;
        size_w2_q  <= size_Weight_layer_2;
        base_ifm_q <= base_addr_IFM;
        size_ifm_q <= size_IFM;
      end
    end
  end

  // Next-state: empty regions are skipped by jumping directly to the next
  // non-empty one, so a zero-size region costs no cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept_start) begin
          cnt_d = '0;
          if (size_Weight_layer_1 != '0)      state_d = S_FETCH_W1;
          else if (size_Weight_layer_2 != '0) state_d = S_FETCH_W2;
          else if (size_IFM != '0)            state_d = S_FETCH_IFM;
          else                                state_d = S_DONE;
        end
      end
      S_FETCH_W1: begin
        if (rd_last) begin
          if (size_w2_q != '0)       state_d = S_FETCH_W2;
          else if (size_ifm_q != '0) state_d = S_FETCH_IFM;
          else                       state_d = S_DRAIN;
        end
      end
      S_FETCH_W2: begin
        if (rd_last) state_d = (size_ifm_q != '0) ? S_FETCH_IFM : S_DRAIN;
      end
      S_FETCH_IFM: begin
        if (rd_last) state_d = S_DRAIN;
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (in_fetch) begin
      if (rd_last)      cnt_d = '0;
      else if (bram_re) cnt_d = cnt_q + ADDR_W'(1);
    end
  end

  // Outputs: BRAM port muxing and current-region selection
  always_comb begin
    bram_addr = '0;
    bram_we   = 1'b0;
    bram_re   = 1'b0;
    rd_sel    = 2'd0;
    cur_base  = '0;
    cur_size  = '0;
    in_fetch  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (load_phase) begin
          bram_addr = wr_addr_global_initial;
          bram_we   = we_global_initial;
        end
      end
      S_FETCH_W1: begin
        in_fetch = 1'b1; rd_sel = 2'd1; cur_base = base_w1_q; cur_size = size_w1_q;
      end
      S_FETCH_W2: begin
        in_fetch = 1'b1; rd_sel = 2'd2; cur_base = base_w2_q; cur_size = size_w2_q;
      end
      S_FETCH_IFM: begin
        in_fetch = 1'b1; rd_sel = 2'd0; cur_base = base_ifm_q; cur_size = size_ifm_q;
      end
      default: ;
    endcase
    if (in_fetch) begin
      bram_re   = out_ready;
      bram_addr = cur_base + cnt_q;
    end
    rd_last = bram_re && ((cnt_q + ADDR_W'(1)) == cur_size);
  end

  assign out_valid     = out_valid_q;
  assign out_data      = out_valid_q ? bram_rdata : '0;
  assign out_sel       = out_sel_q;
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign load_conflict = load_conflict_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_stall_cnt_q;

  always_ff @(posedge clk) begin
    if (reset || accept_start)                              perf_stall_cnt_q <= '0;
    else if (in_fetch && !out_ready && perf_stall_cnt_q != '1) perf_stall_cnt_q <= perf_stall_cnt_q + 32'd1;
  end

  assign perf_stall_cnt = perf_stall_cnt_q;
`endif

endmodule

// File: tb/tb_fused_fetch_scheduler.sv
// Scoreboard bench for fused_fetch_scheduler: a reference model pushes the
// expected read addresses and tagged words for each sequence; a negedge
// monitor pops and compares whenever the DUT reads or presents a word.
module tb_fused_fetch_scheduler;

  localparam int AW = 32;
  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          load_phase = 1'b0;
  logic          we_i = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [AW-1:0] b_ifm = '0, s_ifm = '0, b_w1 = '0, s_w1 = '0, b_w2 = '0, s_w2 = '0;
  logic [AW-1:0] bram_addr;
  logic          bram_we, bram_re;
  logic [DW-1:0] bram_rdata = '0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [1:0]    out_sel;
  logic          busy, done, load_conflict;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]   perf_stall_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  logic [AW-1:0]  exp_addr[$];
  logic [129:0]   exp_data[$];

  fused_fetch_scheduler #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .start(start), .load_phase(load_phase),
    .we_global_initial(we_i), .wr_addr_global_initial(wr_addr),
    .base_addr_IFM(b_ifm), .size_IFM(s_ifm),
    .base_addr_Weight_layer_1(b_w1), .size_Weight_layer_1(s_w1),
    .base_addr_Weight_layer_2(b_w2), .size_Weight_layer_2(s_w2),
    .bram_addr(bram_addr), .bram_we(bram_we), .bram_re(bram_re),
    .bram_rdata(bram_rdata), .out_ready(out_ready), .out_valid(out_valid),
    .out_data(out_data), .out_sel(out_sel), .busy(busy), .done(done),
    .load_conflict(load_conflict)
`ifdef FETCH_PERF_CNT_EN
    , .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] word_of(input logic [31:0] a);
    return {a, ~a, a ^ 32'hA5A5_A5A5, a * 32'd2654435761};
  endfunction

  // BRAM model: one-cycle read latency
  always @(posedge clk) if (bram_re) bram_rdata <= word_of(bram_addr);

  task automatic check(input string name, input logic [129:0] act, input logic [129:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: each region contributes base..base+size-1 (mod 2^32)
  task automatic model_push(input logic [31:0] base, input logic [31:0] size, input logic [1:0] sel);
    for (int unsigned i = 0; i < size; i++) begin
      logic [31:0] a;
      a = base + i;
      exp_addr.push_back(a);
      exp_data.push_back({sel, word_of(a)});
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (out_valid) begin
      if (exp_data.size() == 0) check("unexpected_word", 1, 0);
      else check("word", {out_sel, out_data}, exp_data.pop_front());
    end
    if (bram_re) begin
      check("re_needs_ready", out_ready, 1);
      if (exp_addr.size() == 0) check("unexpected_read", 1, 0);
      else check("read_addr", bram_addr, exp_addr.pop_front());
    end
    if (bram_we && bram_re) check("we_re_exclusive", 1, 0);
  end

  // mode 0: ready always 1; 1: ready toggles starting at 1; 2: random ready
  task automatic run_seq(input logic [31:0] b1, input logic [31:0] s1,
                         input logic [31:0] b2, input logic [31:0] s2,
                         input logic [31:0] bi, input logic [31:0] si,
                         input int mode, input int exp_lat,
                         input int we_cyc, input int rst_cyc);
    int cyc;
    bit seen;
    @(posedge clk); #1;
    b_w1 = b1; s_w1 = s1; b_w2 = b2; s_w2 = s2; b_ifm = bi; s_ifm = si;
    start = 1'b1; load_phase = 1'b0; we_i = 1'b0; out_ready = 1'b1;
    model_push(b1, s1, 2'd1);
    model_push(b2, s2, 2'd2);
    model_push(bi, si, 2'd0);
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 300) begin
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 2 == 1);
        default: out_ready = ($urandom % 4) != 0;
      endcase
      we_i = (cyc == we_cyc);
      if (cyc == rst_cyc) reset = 1'b1;
      @(negedge clk);
      if (cyc == we_cyc) check("we_blocked_busy", bram_we, 0);
      if (cyc == rst_cyc) begin
        @(posedge clk); #1;
        reset = 1'b0;
        we_i = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_load_conflict", load_conflict, 0);
        exp_addr.delete();
        exp_data.delete();
        return;
      end
      if (done) seen = 1'b1;
    end
    we_i = 1'b0;
    if (!seen) check("done_timeout", 0, 1);
    else if (exp_lat >= 0) check("done_latency", cyc, exp_lat);
    check("queue_drained", exp_data.size() + exp_addr.size(), 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("idle_after_done", busy, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_out_valid", out_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_conflict", load_conflict, 0);
    check("reset_out_data", {out_sel, out_data}, 0);
    check("reset_we_re", {bram_we, bram_re}, 0);
`ifdef FETCH_PERF_CNT_EN
    check("reset_perf", perf_stall_cnt, 0);
`endif

    // Host preload window
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      load_phase = 1'b1; we_i = 1'b1; wr_addr = i;
      @(negedge clk);
      check("load_we", bram_we, 1);
      check("load_addr", bram_addr, i);
      check("load_re", bram_re, 0);
    end

    // start during load_phase is ignored
    @(posedge clk); #1;
    we_i = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; load_phase = 1'b0;
    @(negedge clk);
    check("start_in_load_ignored", busy, 0);

    run_seq(32'h100, 4, 32'h200, 2, 32'h0, 3, 0, 11, -1, -1);
    run_seq(32'h100, 4, 32'h200, 2, 32'h0, 3, 1, 19, -1, -1);
`ifdef FETCH_PERF_CNT_EN
    check("perf_stall_cnt", perf_stall_cnt, 8);
`endif
    run_seq(32'h100, 2, 32'h200, 0, 32'hFFFF_FFFE, 3, 0, 7, -1, -1);
    run_seq(32'h0, 0, 32'h0, 0, 32'h0, 0, 0, 1, -1, -1);
    run_seq(32'h10, 2, 32'h20, 3, 32'h30, 1, 0, 8, 4, -1);
    check("conflict_set", load_conflict, 1);

    for (int i = 0; i < 24; i++) begin
      logic [31:0] rb[3];
      logic [31:0] rs[3];
      int tot;
      tot = 0;
      for (int k = 0; k < 3; k++) begin
        rs[k] = $urandom_range(0, 4);
        rb[k] = ($urandom % 3 == 0) ? 32'hFFFF_FFFC + $urandom_range(0, 3) : $urandom;
        tot += int'(rs[k]);
      end
      if (i % 2 == 1) run_seq(rb[0], rs[0], rb[1], rs[1], rb[2], rs[2], 0, (tot > 0) ? tot + 2 : 1, -1, -1);
      else            run_seq(rb[0], rs[0], rb[1], rs[1], rb[2], rs[2], 2, -1, -1, -1);
    end
    check("conflict_sticky", load_conflict, 1);

    // Reset on the 3rd W1 read, then a clean re-fetch from index 0
    run_seq(32'h40, 5, 32'h0, 0, 32'h0, 0, 0, -1, -1, 3);
    run_seq(32'h40, 5, 32'h0, 0, 32'h0, 0, 0, 7, -1, -1);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
